// File: rtl/register_host_pkg.sv
// register_host_pkg: FSM states, pin bit positions and ui byte packing for register_host.
package register_host_pkg;
  typedef enum logic [2:0] {IDLE, STROBE, VSTROBE, WAIT, CAPTURE, DONE} state_t;
  localparam int STB_BIT = 7;
  localparam int WE_BIT = 6;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 4;
  function automatic logic [7:0] pack_ui(input logic stb, input logic we, input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b = '0;
    b[STB_BIT] = stb;
    b[WE_BIT] = we;
    b[ADDR_LSB +: ADDR_W] = addr;
    return b;
  endfunction
endpackage

// File: rtl/register_host.sv
// register_host: sequences single-beat register reads/writes onto the tt_um_register pins.
// Optional write read-back verify: define REGISTER_HOST_VERIFY_EN.
module register_host
  import register_host_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        pin_ui,
  output logic [7:0]        pin_uio,
  input  logic [7:0]        pin_uo
);
  localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);
  localparam state_t AFTER_STB = (READ_LATENCY == 1) ? CAPTURE : WAIT;
  state_t state, next;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] wdata_q;
  logic [2:0] cnt;
  logic hs;
  assign req_ready = state == IDLE && !rst;
  assign hs = req_valid && req_ready;
  assign rsp_valid = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = hs ? STROBE : IDLE;
`ifdef REGISTER_HOST_VERIFY_EN
      STROBE:  next = we_q ? VSTROBE : AFTER_STB;
      VSTROBE: next = AFTER_STB;
`else
      STROBE:  next = we_q ? DONE : AFTER_STB;
`endif
      WAIT:    next = cnt == 3'd1 ? CAPTURE : WAIT;
      CAPTURE: next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // Pins are computed from the upcoming state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      pin_ui <= '0;
      pin_uio <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= next;
      if (hs) begin
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      cnt <= next == WAIT ? (state == WAIT ? cnt - 3'd1 : LAT_M1) : cnt;
      pin_ui <= hs ? pack_ui(1'b1, req_we, req_addr)
              : next == VSTROBE ? pack_ui(1'b1, 1'b0, addr_q)
              : pin_ui & ~8'(1 << STB_BIT);
      pin_uio <= hs ? (req_we ? req_wdata : 8'h00) : next == VSTROBE ? 8'h00 : pin_uio;
      if (next == DONE) rsp_rdata <= state == CAPTURE ? pin_uo : 8'h00;
    end
  end
`ifdef REGISTER_HOST_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) rsp_err <= 1'b0;
    else if (next == DONE) rsp_err <= state == CAPTURE && we_q && pin_uo != wdata_q;
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_register_host.sv
// tb_register_host: directed stimulus, transaction-level model and project pin model for register_host.
module tb_register_host;
  localparam int RL = 2;
`ifdef REGISTER_HOST_VERIFY_EN
  localparam int WR_LAT = 3 + RL;
  localparam bit VER = 1'b1;
`else
  localparam int WR_LAT = 2;
  localparam bit VER = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0, pin_uo = 8'hEE;
  logic req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, pin_ui, pin_uio;
  int tests = 0, fails = 0, cyc = 0;
  bit drop = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  register_host #(.READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .pin_ui(pin_ui), .pin_uio(pin_uio), .pin_uo(pin_uo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Project model: samples strobes, presents read data RL cycles after the sampling edge.
  logic [7:0] pmem [16];
  int uo_at = -1;
  logic [7:0] uo_val = 8'h00;
  always @(negedge clk) if (pin_ui[7] === 1'b1) begin
    if (pin_ui[6]) begin
      if (!drop) pmem[pin_ui[3:0]] = pin_uio;
    end else begin
      uo_at = cyc + RL;
      uo_val = drop ? 8'h00 : pmem[pin_ui[3:0]];
    end
  end
  always @(posedge clk) begin
    #1;
    pin_uo = (cyc == uo_at) ? uo_val : 8'hEE;
  end

  // Transaction model: one outstanding request, timing from handshake cycle.
  logic [7:0] mem [16];
  int stb_at = -1, vstb_at = -1, rsp_at = -1, busy_to = 0;
  logic t_we = 1'b0, t_err = 1'b0, e_err = 1'b0;
  logic [3:0] t_addr = '0;
  logic [7:0] t_wdata = '0, t_rdata = '0, e_rdata = '0, held_ui = '0, held_uio = '0;
  always @(negedge clk) begin
    logic [7:0] eu, ed;
    if (cyc > 0) begin
      eu = cyc == stb_at ? {1'b1, t_we, 2'b00, t_addr} : cyc == vstb_at ? {4'h8, t_addr} : held_ui;
      ed = cyc == stb_at ? (t_we ? t_wdata : 8'h00) : cyc == vstb_at ? 8'h00 : held_uio;
      if (cyc == rsp_at) begin
        e_rdata = t_rdata;
        e_err = t_err;
      end
      check("m_req_ready", req_ready, !rst && cyc > busy_to);
      check("m_rsp_valid", rsp_valid, cyc == rsp_at);
      check("m_pin_ui", pin_ui, eu);
      check("m_pin_uio", pin_uio, ed);
      check("m_rsp_rdata", rsp_rdata, e_rdata);
      check("m_rsp_err", rsp_err, e_err);
      held_ui = eu & 8'h7F;
      held_uio = ed;
      if (rst) begin
        stb_at = -1; vstb_at = -1; rsp_at = -1; busy_to = cyc;
        held_ui = '0; held_uio = '0; e_rdata = '0; e_err = 1'b0;
      end else if (req_valid && cyc > busy_to) begin
        t_we = req_we; t_addr = req_addr; t_wdata = req_wdata;
        stb_at = cyc + 1;
        if (req_we) begin
          vstb_at = VER ? cyc + 2 : -1;
          rsp_at = cyc + WR_LAT;
          t_rdata = VER ? (drop ? 8'h00 : req_wdata) : 8'h00;
          t_err = VER && t_rdata != req_wdata;
          if (!drop) mem[req_addr] = req_wdata;
        end else begin
          vstb_at = -1;
          rsp_at = cyc + 2 + RL;
          t_rdata = drop ? 8'h00 : mem[req_addr];
          t_err = 1'b0;
        end
        busy_to = rsp_at;
      end
    end
  end

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d, input bit keep, output int hc);
    bit ok;
    ok = 1'b0;
    hc = -1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready;
      if (ok) hc = cyc;
      @(posedge clk); #2;
    end
    check("send_accept", ok, 1);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int n = 0; n < 60 && rc < 0; n++) begin
      @(negedge clk);
      if (rsp_valid) rc = cyc;
    end
    check("rsp_arrived", rc >= 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic read_chk(input logic [3:0] a, input logic [7:0] exp);
    int h, r;
    send(1'b0, a, 8'h00, 1'b0, h);
    wait_rsp(r);
    check("rd_lat", r - h, 2 + RL);
    check("rd_data", rsp_rdata, exp);
  endtask

  initial begin
    int h, r;
    int hs [3];
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      pmem[i] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", req_ready, 0);
      check("rst_ui", pin_ui, 0);
      check("rst_uio", pin_uio, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_rdata", rsp_rdata, 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1);
    @(posedge clk); #2;
    send(1'b1, 4'h3, 8'hA5, 1'b0, h);
    @(negedge clk);
    check("wr_pin_ui", pin_ui, 8'hC3);
    check("wr_pin_uio", pin_uio, 8'hA5);
    wait_rsp(r);
    check("wr_lat", r - h, WR_LAT);
    check("wr_err", rsp_err, 0);
    check("wr_rdata", rsp_rdata, VER ? 8'hA5 : 8'h00);
    send(1'b0, 4'h3, 8'h00, 1'b0, h);
    @(negedge clk);
    check("rd_pin_ui", pin_ui, 8'h83);
    check("rd_pin_uio", pin_uio, 8'h00);
    wait_rsp(r);
    check("rd_lat3", r - h, 2 + RL);
    check("rd_a5", rsp_rdata, 8'hA5);
    send(1'b1, 4'hF, 8'hFF, 1'b0, h);
    wait_rsp(r);
    send(1'b1, 4'hC, 8'h3C, 1'b0, h);
    wait_rsp(r);
    read_chk(4'hF, 8'hFF);
    read_chk(4'hC, 8'h3C);
    read_chk(4'h0, 8'h00);
    send(1'b1, 4'h8, 8'h11, 1'b1, hs[0]);
    send(1'b1, 4'h9, 8'h22, 1'b1, hs[1]);
    send(1'b1, 4'hA, 8'h33, 1'b0, hs[2]);
    check("b2b_gap1", hs[1] - hs[0], WR_LAT + 1);
    check("b2b_gap2", hs[2] - hs[1], WR_LAT + 1);
    wait_rsp(r);
    read_chk(4'h8, 8'h11);
    read_chk(4'h9, 8'h22);
    read_chk(4'hA, 8'h33);
    send(1'b0, 4'h9, 8'h00, 1'b0, h);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_stb", pin_ui[7], 0);
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 1);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #2;
`ifdef REGISTER_HOST_VERIFY_EN
    drop = 1'b1;
    send(1'b1, 4'h7, 8'h5A, 1'b0, h);
    wait_rsp(r);
    check("vfy_lat", r - h, 3 + RL);
    check("vfy_err", rsp_err, 1);
    check("vfy_rdata", rsp_rdata, 8'h00);
    drop = 1'b0;
`endif
    read_chk(4'h3, 8'hA5);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
